// File: rtl/store_port_hub_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : store_port_hub_if
// Brief    : Store-bus tap, channel outputs and trace-drain handshake bundle.
// Revision : 1.0
// ============================================================================
interface store_port_hub_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16,
   parameter int N_CH   = 4,
   parameter int DEPTH  = 8
);
   localparam int c_CNT_W = $clog2(DEPTH + 1);

   logic                     we;
   logic [ADDR_W-1:0]        address;
   logic [DATA_W-1:0]        write_data;
   logic [N_CH*DATA_W-1:0]   ch_out;
   logic [N_CH-1:0]          ch_upd;
   logic                     trace_valid;
   logic                     trace_ready;
   logic [ADDR_W-1:0]        trace_addr;
   logic [DATA_W-1:0]        trace_data;
   logic [c_CNT_W-1:0]       trace_count;
   logic                     overflow;
   logic                     clr_overflow;

   modport master (
      output we, address, write_data, trace_ready, clr_overflow,
      input  ch_out, ch_upd, trace_valid, trace_addr, trace_data,
             trace_count, overflow
   );

   modport slave (
      input  we, address, write_data, trace_ready, clr_overflow,
      output ch_out, ch_upd, trace_valid, trace_addr, trace_data,
             trace_count, overflow
   );
endinterface
`default_nettype wire

// File: rtl/store_port_hub.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : store_port_hub
// Brief    : Passive store-bus tap: memory-mapped channel registers + trace FIFO.
// Revision : 1.0
// ============================================================================
module store_port_hub #(
   parameter int              DATA_W    = 32,
   parameter int              ADDR_W    = 16,
   parameter int              N_CH      = 4,
   parameter logic [ADDR_W-1:0] CH_BASE = 16'hFF00,
   parameter int              DEPTH     = 8,
   parameter int              TRACE_ALL = 0
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   store_port_hub_if.slave    bus
);
   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0]  w_offset;
   logic [ADDR_W-1:0]  w_idx;
   logic               w_hit;
   logic               w_log;
   logic               w_full;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;
   logic [c_PTR_W-1:0] w_rd_next;
   logic [c_CNT_W-1:0] w_count_next;

   logic [DATA_W-1:0]  r_ch [N_CH];
   logic [N_CH-1:0]    r_upd;
   logic [ADDR_W-1:0]  r_mem_addr [DEPTH];
   logic [DATA_W-1:0]  r_mem_data [DEPTH];
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic               r_valid;
   logic               r_overflow;
   logic [ADDR_W-1:0]  r_head_addr;
   logic [DATA_W-1:0]  r_head_data;

   // Window decode; the >= test keeps wrapped-around offsets below the base out.
   assign w_offset  = bus.address - CH_BASE;
   assign w_idx     = w_offset >> 2;
   assign w_hit     = bus.we && (bus.address >= CH_BASE) &&
                      (bus.address[1:0] == 2'b00) && (w_idx < ADDR_W'(N_CH));
   assign w_log     = (TRACE_ALL != 0) ? bus.we : w_hit;

   assign w_full    = (r_count == c_CNT_W'(DEPTH));
   assign w_pop     = r_valid && bus.trace_ready;
   assign w_push    = w_log && (!w_full || w_pop);
   assign w_drop    = w_log && w_full && !w_pop;
   assign w_rd_next = r_rd_ptr + c_PTR_W'(1);

   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop)
         w_count_next = r_count + c_CNT_W'(1);
      else if (w_pop && !w_push)
         w_count_next = r_count - c_CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++)
            r_ch[i] <= '0;
         r_upd <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (w_hit && (w_idx == ADDR_W'(i)))
               r_ch[i] <= bus.write_data;
            r_upd[i] <= w_hit && (w_idx == ADDR_W'(i));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && w_push) begin
         r_mem_addr[r_wr_ptr] <= bus.address;
         r_mem_data[r_wr_ptr] <= bus.write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_valid     <= 1'b0;
         r_overflow  <= 1'b0;
         r_head_addr <= '0;
         r_head_data <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_pop)
            r_rd_ptr <= w_rd_next;
         r_count <= w_count_next;
         r_valid <= (w_count_next != '0);

         // Head register: refill from the next slot, or from the incoming store
         // when it is the only entry left; otherwise hold the last popped value.
         if (w_pop) begin
            if (r_count > c_CNT_W'(1)) begin
               r_head_addr <= r_mem_addr[w_rd_next];
               r_head_data <= r_mem_data[w_rd_next];
            end else if (w_push) begin
               r_head_addr <= bus.address;
               r_head_data <= bus.write_data;
            end
         end else if (w_push && !r_valid) begin
            r_head_addr <= bus.address;
            r_head_data <= bus.write_data;
         end

         if (w_drop)
            r_overflow <= 1'b1;
         else if (bus.clr_overflow)
            r_overflow <= 1'b0;
      end
   end

   generate
      for (genvar g = 0; g < N_CH; g++) begin : g_ch_pack
         assign bus.ch_out[g*DATA_W +: DATA_W] = r_ch[g];
      end
   endgenerate

   assign bus.ch_upd      = r_upd;
   assign bus.trace_valid = r_valid;
   assign bus.trace_addr  = r_head_addr;
   assign bus.trace_data  = r_head_data;
   assign bus.trace_count = r_count;
   assign bus.overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_store_port_hub.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_store_port_hub
// Brief    : Directed self-checking bench for store_port_hub (both trace modes).
// Revision : 1.1
// ============================================================================
module tb_store_port_hub;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int N_CH   = 4;
    localparam int DEPTH  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    store_port_hub_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_CH(N_CH), .DEPTH(DEPTH)) bus0 ();
    store_port_hub_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_CH(N_CH), .DEPTH(DEPTH)) bus1 ();

    store_port_hub #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_CH(N_CH), .CH_BASE(16'hFF00),
        .DEPTH(DEPTH), .TRACE_ALL(0)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    store_port_hub #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_CH(N_CH), .CH_BASE(16'hFF00),
        .DEPTH(DEPTH), .TRACE_ALL(1)
    ) u_dut_all (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    task automatic fail(input string tag);
        n_fail++;
        $error("FAIL %s", tag);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store0(input logic [15:0] a, input logic [31:0] d);
        bus0.we         = 1'b1;
        bus0.address    = a;
        bus0.write_data = d;
        step();
        bus0.we         = 1'b0;
    endtask

    task automatic chk_head(input string tag, input logic [15:0] a, input logic [31:0] d);
        n_assert++;
        if (bus0.trace_valid !== 1'b1) fail({tag, "_valid"});
        n_assert++;
        if (bus0.trace_addr !== a) fail({tag, "_addr"});
        n_assert++;
        if (bus0.trace_data !== d) fail({tag, "_data"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [47:0]  q[$];
        logic         pu, rd, hold, pop;
        logic [15:0]  a;
        logic [31:0]  d, saved;
        logic [31:0]  exp_d;

        bus0.we = 1'b1; bus0.address = 16'hFF08; bus0.write_data = 32'h1234_5678;
        bus0.trace_ready = 1'b0; bus0.clr_overflow = 1'b0;
        bus1.we = 1'b1; bus1.address = 16'hFF00; bus1.write_data = 32'h1234_5678;
        bus1.trace_ready = 1'b0; bus1.clr_overflow = 1'b0;

        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1; bus0.we = 1'b0; bus1.we = 1'b0;
        step();
        n_assert++; if (bus0.ch_out !== 128'h0) fail("rst_ch_out");
        n_assert++; if (bus0.ch_upd !== 4'b0000) fail("rst_ch_upd");
        n_assert++; if (bus0.trace_valid !== 1'b0) fail("rst_valid");
        n_assert++; if (bus0.trace_count !== 4'd0) fail("rst_count");
        n_assert++; if (bus0.overflow !== 1'b0) fail("rst_overflow");
        n_assert++; if (bus0.trace_addr !== 16'h0) fail("rst_addr");
        n_assert++; if (bus0.trace_data !== 32'h0) fail("rst_data");
        n_assert++; if (bus1.trace_count !== 4'd0) fail("rst_all_count");

        store0(16'hFF08, 32'hDEAD_BEEF);
        n_assert++; if (bus0.ch_out !== {32'h0, 32'hDEAD_BEEF, 64'h0}) fail("dec_ch2");
        n_assert++; if (bus0.ch_upd !== 4'b0100) fail("dec_upd");
        n_assert++; if (bus0.trace_count !== 4'd1) fail("dec_count");
        step();
        n_assert++; if (bus0.ch_upd !== 4'b0000) fail("dec_upd_pulse_end");
        store0(16'hFF0A, 32'h1111_1111);
        n_assert++; if (bus0.ch_out !== {32'h0, 32'hDEAD_BEEF, 64'h0}) fail("dec_misalign_ch");
        n_assert++; if (bus0.ch_upd !== 4'b0000) fail("dec_misalign_upd");
        store0(16'hFF10, 32'h2222_2222);
        n_assert++; if (bus0.ch_out !== {32'h0, 32'hDEAD_BEEF, 64'h0}) fail("dec_above_ch");
        n_assert++; if (bus0.ch_upd !== 4'b0000) fail("dec_above_upd");
        store0(16'h0008, 32'h3333_3333);
        n_assert++; if (bus0.ch_out !== {32'h0, 32'hDEAD_BEEF, 64'h0}) fail("dec_below_ch");
        n_assert++; if (bus0.trace_count !== 4'd1) fail("dec_below_count");
        chk_head("dec_head", 16'hFF08, 32'hDEAD_BEEF);
        bus0.trace_ready = 1'b1;
        step();
        bus0.trace_ready = 1'b0;
        n_assert++; if (bus0.trace_valid !== 1'b0) fail("dec_drain_valid");
        n_assert++; if (bus0.trace_count !== 4'd0) fail("dec_drain_count");

        store0(16'hFF00, 32'd1);
        n_assert++; if (bus0.trace_valid !== 1'b1) fail("fifo_valid_lat");
        n_assert++; if (bus0.trace_count !== 4'd1) fail("fifo_count1");
        store0(16'hFF04, 32'd2);
        store0(16'hFF0C, 32'd3);
        n_assert++; if (bus0.trace_count !== 4'd3) fail("fifo_count3");
        n_assert++; if (bus0.ch_out !== {32'd3, 32'hDEAD_BEEF, 32'd2, 32'd1}) fail("fifo_ch");
        bus0.trace_ready = 1'b1;
        chk_head("fifo_e0", 16'hFF00, 32'd1);
        step();
        chk_head("fifo_e1", 16'hFF04, 32'd2);
        step();
        chk_head("fifo_e2", 16'hFF0C, 32'd3);
        step();
        n_assert++; if (bus0.trace_valid !== 1'b0) fail("fifo_empty_valid");
        n_assert++; if (bus0.trace_count !== 4'd0) fail("fifo_empty_count");
        bus0.trace_ready = 1'b0;

        for (int k = 0; k < 9; k++)
            store0(16'hFF00, 32'h100 + 32'(k));
        n_assert++; if (bus0.trace_count !== 4'd8) fail("full_count");
        n_assert++; if (bus0.overflow !== 1'b1) fail("full_overflow");
        chk_head("full_head", 16'hFF00, 32'h100);
        bus0.trace_ready = 1'b1;
        store0(16'hFF00, 32'h200);
        bus0.trace_ready = 1'b0;
        n_assert++; if (bus0.trace_count !== 4'd8) fail("full_pushpop_count");
        chk_head("full_pushpop_head", 16'hFF00, 32'h101);
        bus0.clr_overflow = 1'b1;
        step();
        n_assert++; if (bus0.overflow !== 1'b0) fail("clr_overflow");
        store0(16'hFF00, 32'h300);
        bus0.clr_overflow = 1'b0;
        n_assert++; if (bus0.overflow !== 1'b1) fail("clr_vs_drop");
        n_assert++; if (bus0.trace_count !== 4'd8) fail("clr_vs_drop_count");
        bus0.trace_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_d = (k < 7) ? 32'h101 + 32'(k) : 32'h200;
            n_assert++; if (bus0.trace_valid !== 1'b1) fail("full_drain_valid");
            n_assert++; if (bus0.trace_addr !== 16'hFF00) fail("full_drain_addr");
            n_assert++; if (bus0.trace_data !== exp_d) fail("full_drain_data");
            step();
        end
        bus0.trace_ready = 1'b0;
        n_assert++; if (bus0.trace_valid !== 1'b0) fail("full_drained_valid");
        bus0.clr_overflow = 1'b1;
        step();
        bus0.clr_overflow = 1'b0;

        for (int c = 0; c < 20; c++) begin
            pu = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            a  = 16'hFF00 + 16'(4 * $urandom_range(0, 3));
            d  = $urandom;
            n_assert++; if (int'(bus0.trace_count) !== q.size()) fail("wrap_count");
            n_assert++; if (bus0.trace_valid !== 1'(q.size() != 0)) fail("wrap_valid");
            n_assert++; if (bus0.trace_count > 4'd8) fail("wrap_count_max");
            if (q.size() != 0) begin
                n_assert++;
                if ({bus0.trace_addr, bus0.trace_data} !== q[0]) fail("wrap_head");
            end
            hold  = (q.size() != 0) && !rd;
            saved = bus0.trace_data;
            pop   = (q.size() != 0) && rd;
            bus0.we = pu; bus0.address = a; bus0.write_data = d; bus0.trace_ready = rd;
            if (pop)
                void'(q.pop_front());
            if (pu && (q.size() < DEPTH || pop))
                q.push_back({a, d});
            step();
            if (hold) begin
                n_assert++;
                if (bus0.trace_data !== saved) fail("wrap_stable");
            end
        end
        bus0.we = 1'b0;
        bus0.trace_ready = 1'b1;
        for (int k = 0; k < 12 && q.size() != 0; k++) begin
            n_assert++;
            if ({bus0.trace_valid, bus0.trace_addr, bus0.trace_data} !== {1'b1, q[0]}) fail("wrap_drain");
            void'(q.pop_front());
            step();
        end
        bus0.trace_ready = 1'b0;
        n_assert++; if (bus0.trace_valid !== 1'b0) fail("wrap_end_valid");
        n_assert++; if (bus0.trace_count !== 4'd0) fail("wrap_end_count");

        bus1.we = 1'b1; bus1.address = 16'h0010; bus1.write_data = 32'hAA;
        step();
        n_assert++; if (bus1.trace_count !== 4'd1) fail("all_first_count");
        n_assert++; if (bus1.ch_out !== 128'h0) fail("all_first_ch");
        bus1.address = 16'hFF00; bus1.write_data = 32'hBB;
        step();
        bus1.we = 1'b0;
        n_assert++; if (bus1.trace_count !== 4'd2) fail("all_count");
        n_assert++; if (bus1.ch_out !== {96'h0, 32'hBB}) fail("all_ch");
        n_assert++; if ({bus1.trace_addr, bus1.trace_data} !== {16'h0010, 32'hAA}) fail("all_head");
        bus1.trace_ready = 1'b1;
        step();
        n_assert++; if ({bus1.trace_addr, bus1.trace_data} !== {16'hFF00, 32'hBB}) fail("all_head2");
        step();
        bus1.trace_ready = 1'b0;
        n_assert++; if (bus1.trace_valid !== 1'b0) fail("all_empty");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
